// File: rtl/sawtooth_profile_sched_if.sv
// Control/status bundle between the profile scheduler, its byte/tick sources and the
// sawtooth counter datapath.
interface sawtooth_profile_sched_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          tick_i;
  logic          v_i;
  logic [W-1:0]  din_i;
  logic          abort_i;
  logic          wrap_i;
  logic [W-1:0]  lo_o;
  logic [W-1:0]  hi_o;
  logic          cnt_load_o;
  logic          cnt_en_o;
  logic          active_o;
  logic          ovf_o;
  logic [LW-1:0] level_o;
  logic [1:0]    byte_idx_o;
  logic [1:0]    state_o;

  modport master (
    output tick_i, v_i, din_i, abort_i, wrap_i,
    input  lo_o, hi_o, cnt_load_o, cnt_en_o, active_o, ovf_o, level_o, byte_idx_o, state_o
  );

  modport slave (
    input  tick_i, v_i, din_i, abort_i, wrap_i,
    output lo_o, hi_o, cnt_load_o, cnt_en_o, active_o, ovf_o, level_o, byte_idx_o, state_o
  );
endinterface

// File: rtl/sawtooth_profile_sched.sv
// Assembles {N1,N2,REPS} profiles from a byte stream, queues them, and sequences the
// sawtooth counter through them, switching bounds only at period wrap boundaries.
module sawtooth_profile_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  sawtooth_profile_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StHold = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  lo_q, hi_q;
  logic [W-1:0]  rem_q, rem_d;
  logic          inf_q, inf_d;
  logic [1:0]    idx_q;
  logic [W-1:0]  n1_q, n2_q;
  logic [LW-1:0] level_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          ovf_q;

  logic [W-1:0]  lo_mem   [DEPTH];
  logic [W-1:0]  hi_mem   [DEPTH];
  logic [W-1:0]  reps_mem [DEPTH];

  logic          pop, push_req, push_ok, full, level_nz;
  logic [W-1:0]  norm_lo, norm_hi;

  assign level_nz = (level_q != '0);
  assign full     = (level_q == LW'(DEPTH));
  assign push_req = bus.v_i && (idx_q == 2'd2) && !bus.abort_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign norm_lo  = (n1_q < n2_q) ? n1_q : n2_q;
  assign norm_hi  = (n1_q < n2_q) ? n2_q : n1_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rem_d   = rem_q;
    inf_d   = inf_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (level_nz) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        if (bus.wrap_i) begin
          if (inf_q) begin
            if (level_nz) begin
              pop     = 1'b1;
              state_d = StLoad;
            end
          end else begin
            rem_d = rem_q - W'(1);
            if (rem_q == W'(1)) begin
              if (level_nz) begin
                pop     = 1'b1;
                state_d = StLoad;
              end else begin
                state_d = StHold;
              end
            end
          end
        end
      end
    endcase
    if (pop) begin
      rem_d = reps_mem[rd_ptr_q];
      inf_d = (reps_mem[rd_ptr_q] == '0);
    end
    if (bus.abort_i) begin
      state_d = StIdle;
      pop     = 1'b0;
      rem_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      rem_q    <= '0;
      inf_q    <= 1'b0;
      idx_q    <= 2'd0;
      n1_q     <= '0;
      n2_q     <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      inf_q   <= inf_d;
      ovf_q   <= push_req && full && !pop;
      if (pop) begin
        lo_q <= lo_mem[rd_ptr_q];
        hi_q <= hi_mem[rd_ptr_q];
      end
      if (bus.abort_i) begin
        idx_q    <= 2'd0;
        level_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (bus.v_i) begin
          unique case (idx_q)
            2'd0:    n1_q <= bus.din_i;
            2'd1:    n2_q <= bus.din_i;
            default: ;
          endcase
          idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        level_q <= level_q + LW'(push_ok) - LW'(pop);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      lo_mem[wr_ptr_q]   <= norm_lo;
      hi_mem[wr_ptr_q]   <= norm_hi;
      reps_mem[wr_ptr_q] <= bus.din_i;
    end
  end

  assign bus.lo_o       = lo_q;
  assign bus.hi_o       = hi_q;
  assign bus.cnt_load_o = (state_q == StLoad);
  assign bus.cnt_en_o   = bus.tick_i && (state_q == StRun);
  assign bus.active_o   = (state_q == StRun);
  assign bus.ovf_o      = ovf_q;
  assign bus.level_o    = level_q;
  assign bus.byte_idx_o = idx_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_sawtooth_profile_sched.sv
// Directed table-driven bench for sawtooth_profile_sched plus hand sequences for the
// overflow, abort, tick-mirroring and asynchronous reset corners.
module tb_sawtooth_profile_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  sawtooth_profile_sched_if #(.DEPTH(DEPTH), .W(W)) bus ();

  sawtooth_profile_sched #(.DEPTH(DEPTH), .W(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [7:0] din;
    logic       abort;
    logic       wrap;
    logic       tick;
    logic [1:0] st;
    logic [2:0] lvl;
    logic [1:0] idx;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       ld;
    logic       en;
    logic       ovf;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] din, logic abort, logic wrap, logic tick,
                              logic [1:0] st, logic [2:0] lvl, logic [1:0] idx,
                              logic [7:0] lo, logic [7:0] hi, logic ld, logic en, logic ovf);
    vec_t t;
    t.v = v; t.din = din; t.abort = abort; t.wrap = wrap; t.tick = tick;
    t.st = st; t.lvl = lvl; t.idx = idx; t.lo = lo; t.hi = hi;
    t.ld = ld; t.en = en; t.ovf = ovf;
    return t;
  endfunction

  function automatic logic [31:0] snap();
    return {5'd0, bus.state_o, bus.level_o, bus.byte_idx_o, bus.lo_o, bus.hi_o,
            bus.cnt_load_o, bus.cnt_en_o, bus.ovf_o, bus.active_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(vec_t t, string name);
    logic [31:0] exp;
    bus.v_i = t.v; bus.din_i = t.din; bus.abort_i = t.abort;
    bus.wrap_i = t.wrap; bus.tick_i = t.tick;
    @(posedge clk);
    #1;
    exp = {5'd0, t.st, t.lvl, t.idx, t.lo, t.hi, t.ld, t.en, t.ovf, (t.st == 2'b10)};
    check(name, snap(), exp);
    bus.v_i = 1'b0; bus.din_i = 8'd0; bus.abort_i = 1'b0; bus.wrap_i = 1'b0; bus.tick_i = 1'b0;
  endtask

  initial begin
    bus.v_i = 1'b0; bus.din_i = 8'd0; bus.abort_i = 1'b0; bus.wrap_i = 1'b0; bus.tick_i = 1'b0;

    //            v  din abt wrp tck  st  lvl idx lo  hi  ld en ovf
    tbl.push_back(mk(1, 20, 0, 0, 0, 2'd0, 3'd0, 2'd1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 40, 0, 0, 0, 2'd0, 3'd0, 2'd2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 2'd0, 3'd1, 2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd1, 3'd0, 2'd0, 20, 40, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0, 20, 40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd2, 3'd0, 2'd0, 20, 40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 20, 40, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd3, 3'd0, 2'd0, 20, 40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2'd3, 3'd0, 2'd0, 20, 40, 0, 0, 0));
    tbl.push_back(mk(1, 76, 0, 0, 0, 2'd3, 3'd0, 2'd1, 20, 40, 0, 0, 0));
    tbl.push_back(mk(1, 15, 0, 0, 0, 2'd3, 3'd0, 2'd2, 20, 40, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'd3, 3'd1, 2'd0, 20, 40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd1, 3'd0, 2'd0, 15, 76, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0, 15, 76, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd2, 3'd0, 2'd0, 15, 76, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 2'd2, 3'd0, 2'd1, 15, 76, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 0, 0, 2'd2, 3'd0, 2'd2, 15, 76, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd2, 3'd1, 2'd0, 15, 76, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'd2, 3'd1, 2'd0, 15, 76, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2'd1, 3'd0, 2'd0, 5, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0, 5, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd3, 3'd0, 2'd0, 5, 9, 0, 0, 0));

    #5;
    bus.tick_i = 1'b1;
    #1;
    check("reset_state", snap(), 32'd0);
    bus.tick_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Infinite profile 1,2,0 so queued entries are not drained.
    apply(mk(1, 1, 0, 0, 0, 2'd3, 3'd0, 2'd1, 5, 9, 0, 0, 0), "inf_b0");
    apply(mk(1, 2, 0, 0, 0, 2'd3, 3'd0, 2'd2, 5, 9, 0, 0, 0), "inf_b1");
    apply(mk(1, 0, 0, 0, 0, 2'd3, 3'd1, 2'd0, 5, 9, 0, 0, 0), "inf_b2");
    apply(mk(0, 0, 0, 0, 0, 2'd1, 3'd0, 2'd0, 1, 2, 1, 0, 0), "inf_load");
    apply(mk(0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0, 1, 2, 0, 0, 0), "inf_run");
    for (int e = 0; e < 4; e++) begin
      apply(mk(1, 8'(10 + e), 0, 0, 0, 2'd2, 3'(e), 2'd1, 1, 2, 0, 0, 0),
            $sformatf("fill%0d_b0", e));
      apply(mk(1, 8'(30 + e), 0, 0, 0, 2'd2, 3'(e), 2'd2, 1, 2, 0, 0, 0),
            $sformatf("fill%0d_b1", e));
      apply(mk(1, 1, 0, 0, 0, 2'd2, 3'(e + 1), 2'd0, 1, 2, 0, 0, 0),
            $sformatf("fill%0d_b2", e));
    end
    apply(mk(1, 99, 0, 0, 0, 2'd2, 3'd4, 2'd1, 1, 2, 0, 0, 0), "ovf_b0");
    apply(mk(1, 98, 0, 0, 0, 2'd2, 3'd4, 2'd2, 1, 2, 0, 0, 0), "ovf_b1");
    apply(mk(1, 1, 0, 0, 0, 2'd2, 3'd4, 2'd0, 1, 2, 0, 0, 1), "ovf_drop");
    apply(mk(0, 0, 0, 0, 0, 2'd2, 3'd4, 2'd0, 1, 2, 0, 0, 0), "ovf_clear");
    apply(mk(1, 50, 0, 0, 0, 2'd2, 3'd4, 2'd1, 1, 2, 0, 0, 0), "pp_b0");
    apply(mk(1, 60, 0, 0, 0, 2'd2, 3'd4, 2'd2, 1, 2, 0, 0, 0), "pp_b1");
    apply(mk(1, 1, 0, 1, 0, 2'd1, 3'd4, 2'd0, 10, 30, 1, 0, 0), "push_pop_full");
    apply(mk(0, 0, 0, 0, 0, 2'd2, 3'd4, 2'd0, 10, 30, 0, 0, 0), "pp_run");
    apply(mk(0, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0, 11, 31, 1, 0, 0), "next_load");
    apply(mk(0, 0, 0, 0, 0, 2'd2, 3'd3, 2'd0, 11, 31, 0, 0, 0), "next_run");
    apply(mk(1, 7, 0, 0, 0, 2'd2, 3'd3, 2'd1, 11, 31, 0, 0, 0), "abort_pre");
    apply(mk(1, 8, 1, 1, 0, 2'd0, 3'd0, 2'd0, 11, 31, 0, 0, 0), "abort");
    apply(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 11, 31, 0, 0, 0), "abort_idle");

    apply(mk(1, 100, 0, 0, 0, 2'd0, 3'd0, 2'd1, 11, 31, 0, 0, 0), "tk_b0");
    apply(mk(1, 200, 0, 0, 0, 2'd0, 3'd0, 2'd2, 11, 31, 0, 0, 0), "tk_b1");
    apply(mk(1, 0, 0, 0, 0, 2'd0, 3'd1, 2'd0, 11, 31, 0, 0, 0), "tk_b2");
    apply(mk(0, 0, 0, 0, 1, 2'd1, 3'd0, 2'd0, 100, 200, 1, 0, 0), "tick_in_load");
    apply(mk(0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0, 100, 200, 0, 0, 0), "tk_run");
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.tick_i = (c % 8 == 0);
      #1;
      check($sformatf("cnt_en_mirror[%0d]", c), 32'(bus.cnt_en_o), 32'(c % 8 == 0));
    end
    bus.tick_i = 1'b0;

    apply(mk(1, 3, 0, 0, 0, 2'd2, 3'd0, 2'd1, 100, 200, 0, 0, 0), "rq_b0");
    apply(mk(1, 4, 0, 0, 0, 2'd2, 3'd0, 2'd2, 100, 200, 0, 0, 0), "rq_b1");
    apply(mk(1, 1, 0, 0, 0, 2'd2, 3'd1, 2'd0, 100, 200, 0, 0, 0), "rq_b2");
    @(negedge clk);
    bus.tick_i = 1'b1;
    #1;
    check("pre_reset_en", 32'(bus.cnt_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", snap(), 32'd0);
    repeat (5) @(negedge clk);
    check("reset_held", snap(), 32'd0);
    bus.tick_i = 1'b0;
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0), "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
